// File: rtl/stream_transpose.sv
// rtl/stream_transpose.sv - N x N block transposer / pass-through for row streams
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   in_val/in_rdy   input row handshake; in_mode (1 = transpose) sampled with row 0
//   in_row          input row, NUM_PE elements of DATA_WIDTH bits
//   out_val/out_rdy output row handshake; out_row and out_last are registered
//   out_last        output row is the last row of its block
//
// Build option: STREAM_TRANSPOSE_PINGPONG_EN selects two alternating banks;
// without it a single bank is used and input stalls while a block drains.
module stream_transpose #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic                  in_mode,
    input  logic [DATA_WIDTH-1:0] in_row  [0:NUM_PE-1],
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_row [0:NUM_PE-1],
    output logic                  out_last
);

    localparam int CW = $clog2(NUM_PE);
`ifdef STREAM_TRANSPOSE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    // Bank pointers toggle only when there is a second bank to go to.
    localparam logic          BANK_STEP = (NB == 2);
    localparam logic [CW-1:0] LAST_ROW  = CW'(NUM_PE - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    bank_state_t           bank_state     [NB];
    bank_state_t           bank_state_nxt [NB];
    logic                  bank_mode      [NB];
    logic [DATA_WIDTH-1:0] mem            [NB][NUM_PE][NUM_PE];

    logic                  wr_bank;
    logic [CW-1:0]         wr_cnt;
    logic                  ld_bank;
    logic [CW-1:0]         ld_cnt;
    logic                  out_bank;     // bank the row held in out_row came from

    logic                  wr_fire;
    logic                  out_fire;
    logic                  ld_avail;
    logic                  ld_fire;
    logic [DATA_WIDTH-1:0] ld_row [0:NUM_PE-1];

    always_comb begin
        in_rdy = (bank_state[wr_bank] == BANK_EMPTY) ||
                 (bank_state[wr_bank] == BANK_FILLING);
`ifdef STREAM_TRANSPOSE_PINGPONG_EN
        // Once the last row of a draining bank sits in out_row the storage
        // holds nothing still needed, so the next block may start refilling
        // it. This keeps input flowing with no gap between blocks.
        if (bank_state[wr_bank] == BANK_DRAINING && out_val && out_last &&
            out_bank == wr_bank) begin
            in_rdy = 1'b1;
        end
`endif
    end

    assign wr_fire  = in_val && in_rdy && !rst;
    assign out_fire = out_val && out_rdy;
    // A draining bank with ld_cnt back at 0 has already handed its last row
    // to out_row and only waits for that row's transfer.
    assign ld_avail = (bank_state[ld_bank] == BANK_FULL) ||
                      (bank_state[ld_bank] == BANK_DRAINING && ld_cnt != '0);
    assign ld_fire  = ld_avail && (!out_val || out_rdy);

    always_comb begin
        for (int c = 0; c < NUM_PE; c++) begin
            ld_row[c] = bank_mode[ld_bank] ? mem[ld_bank][c][ld_cnt]
                                           : mem[ld_bank][ld_cnt][c];
        end
    end

    // Write events take priority: a refilled bank must not be emptied by the
    // late transfer of its previous block's last row.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            bank_state_nxt[b] = bank_state[b];
            if (wr_fire && wr_bank == 1'(b) && wr_cnt == '0) begin
                bank_state_nxt[b] = BANK_FILLING;
            end else if (wr_fire && wr_bank == 1'(b) && wr_cnt == LAST_ROW) begin
                bank_state_nxt[b] = BANK_FULL;
            end else if (ld_fire && ld_bank == 1'(b) && bank_state[b] == BANK_FULL) begin
                bank_state_nxt[b] = BANK_DRAINING;
            end else if (out_fire && out_last && out_bank == 1'(b) &&
                         bank_state[b] == BANK_DRAINING) begin
                bank_state_nxt[b] = BANK_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                bank_state[b] <= BANK_EMPTY;
                bank_mode[b]  <= 1'b0;
            end
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
            ld_bank  <= 1'b0;
            ld_cnt   <= '0;
            out_bank <= 1'b0;
            out_val  <= 1'b0;
            out_last <= 1'b0;
            for (int c = 0; c < NUM_PE; c++) begin
                out_row[c] <= '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                bank_state[b] <= bank_state_nxt[b];
            end

            if (wr_fire) begin
                if (wr_cnt == '0) begin
                    bank_mode[wr_bank] <= in_mode;
                end
                if (wr_cnt == LAST_ROW) begin
                    wr_cnt  <= '0;
                    wr_bank <= wr_bank ^ BANK_STEP;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end

            if (ld_fire) begin
                out_row  <= ld_row;
                out_val  <= 1'b1;
                out_last <= (ld_cnt == LAST_ROW);
                out_bank <= ld_bank;
                if (ld_cnt == LAST_ROW) begin
                    ld_cnt  <= '0;
                    ld_bank <= ld_bank ^ BANK_STEP;
                end else begin
                    ld_cnt <= ld_cnt + 1'b1;
                end
            end else if (out_fire) begin
                out_val  <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int c = 0; c < NUM_PE; c++) begin
                mem[wr_bank][wr_cnt][c] <= in_row[c];
            end
        end
    end

endmodule

// File: tb/tb_stream_transpose.sv
// tb/tb_stream_transpose.sv - directed self-checking bench for stream_transpose (N=4, 16-bit)
module tb_stream_transpose;

    localparam int DW = 16;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_val;
    logic          in_rdy;
    logic          in_mode;
    logic [DW-1:0] in_row  [0:N-1];
    logic          out_val;
    logic          out_rdy;
    logic [DW-1:0] out_row [0:N-1];
    logic          out_last;

    stream_transpose #(.DATA_WIDTH(DW), .NUM_PE(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_mode  (in_mode),
        .in_row   (in_row),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_row  (out_row),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] row;
        logic        last;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   stalls = 0;
    exp_t expq[$];
    int   xfer_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] val(input int b, input int r, input int c);
        return DW'(b * 256 + r * 16 + c);
    endfunction

    function automatic logic [63:0] exp_row(input int b, input logic mode, input int r);
        logic [63:0] res;
        res = '0;
        for (int c = 0; c < N; c++) begin
            res[63-16*c -: 16] = mode ? val(b, c, r) : val(b, r, c);
        end
        return res;
    endfunction

    function automatic logic [63:0] pack_row(input logic [DW-1:0] r [0:N-1]);
        return {r[0], r[1], r[2], r[3]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output scoreboard: a transfer happens on the edge following this sample.
    always @(negedge clk) begin
        if (!rst && out_val && out_rdy) begin
            check("row_available", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
                exp_t e;
                e = expq.pop_front();
                check("out_row", pack_row(out_row), e.row);
                check("out_last", 64'(out_last), 64'(e.last));
                xfer_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input int b, input logic m0, input logic mo,
                              input int nrows, input bit push);
        if (push) begin
            for (int r = 0; r < N; r++) begin
                exp_t e;
                e.row  = exp_row(b, m0, r);
                e.last = (r == N - 1);
                expq.push_back(e);
            end
        end
        for (int r = 0; r < nrows; r++) begin
            int  tmo;
            bit  acc;
            in_val  = 1'b1;
            in_mode = (r == 0) ? m0 : mo;
            for (int c = 0; c < N; c++) in_row[c] = val(b, r, c);
            tmo = 0;
            forever begin
                acc = in_rdy;
                if (!acc) stalls++;
                step();
                if (acc) break;
                tmo++;
                if (tmo > 200) begin
                    check("in_rdy_wait", 64'(tmo), 64'd0);
                    break;
                end
            end
        end
        in_val = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 300) begin
            step();
            t++;
        end
        check("drain_empty", 64'(expq.size()), 64'd0);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        rst     = 1'b1;
        in_val  = 1'b0;
        in_mode = 1'b0;
        out_rdy = 1'b1;
        for (int c = 0; c < N; c++) in_row[c] = '0;
        step();
        rst = 1'b0;
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_out_val", 64'(out_val), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_row", pack_row(out_row), 64'h0);

        // Single transposed block with one-cycle latency after the row-3 write.
        send_block(0, 1'b1, 1'b1, N, 1'b1);
        check("lat_not_yet", 64'(out_val), 64'd0);
        step();
        check("lat_val", 64'(out_val), 64'd1);
        check("lat_row0", pack_row(out_row), 64'h0000_0010_0020_0030);
        check("lat_last0", 64'(out_last), 64'd0);
        drain();

        // Pass-through latched at row 0; later mode changes ignored.
        send_block(1, 1'b0, 1'b1, N, 1'b1);
        drain();

        // Output stall while row 2 is presented.
        send_block(0, 1'b1, 1'b1, N, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (out_val && out_row[0] == 16'h0002) found = 1'b1;
        end
        check("stall_reached", 64'(found), 64'd1);
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_row", pack_row(out_row), 64'h0002_0012_0022_0032);
            check("stall_val", 64'(out_val), 64'd1);
        end
        out_rdy = 1'b1;
        drain();

        // Three blocks back to back.
        stalls = 0;
        xfer_cyc.delete();
        send_block(2, 1'b1, 1'b1, N, 1'b1);
        send_block(3, 1'b0, 1'b0, N, 1'b1);
        send_block(4, 1'b1, 1'b0, N, 1'b1);
        drain();
        check("b2b_rows", 64'(xfer_cyc.size()), 64'd12);
`ifdef STREAM_TRANSPOSE_PINGPONG_EN
        check("b2b_stalls", 64'(stalls), 64'd0);
        if (xfer_cyc.size() >= 12) check("b2b_span", 64'(xfer_cyc[11] - xfer_cyc[0]), 64'd11);
`else
        check("b2b_stalls", 64'(stalls), 64'd10);
        if (xfer_cyc.size() >= 12) check("b2b_span", 64'(xfer_cyc[11] - xfer_cyc[0]), 64'd21);
`endif

        // Reset discards a stored block and a partial block.
        out_rdy = 1'b0;
        send_block(5, 1'b1, 1'b1, N, 1'b0);
        step();
        check("pre_rst_val", 64'(out_val), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("post_rst_val", 64'(out_val), 64'd0);
        check("post_rst_row", pack_row(out_row), 64'h0);
        check("post_rst_in_rdy", 64'(in_rdy), 64'd1);
        out_rdy = 1'b1;
        send_block(6, 1'b1, 1'b1, 3, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_val", 64'(out_val), 64'd0);
        check("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
        send_block(7, 1'b1, 1'b1, N, 1'b1);
        check("new_blk_wait", 64'(out_val), 64'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
